// File: rtl/demux_sequencer.sv
// Serialises a 4-bit word onto din while stepping the demux select {x,y} through the
// enabled channels in ascending order, holding each slot for HOLD cycles.
module demux_sequencer #(
  parameter int unsigned HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic [3:0] ch_en,
  output logic       din,
  output logic       x,
  output logic       y,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    StIdle,
    StSlot,
    StDone
  } state_e;

  localparam logic [7:0] HoldLast = 8'(HOLD - 1);

  state_e     state_q, state_d;
  logic [3:0] word_q, word_d;
  logic [3:0] mask_q, mask_d;
  logic [1:0] ch_q, ch_d;
  logic [7:0] cnt_q, cnt_d;

  logic din_q, din_d;
  logic x_q, x_d;
  logic y_q, y_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic ready_q, ready_d;

  logic [2:0] hit;

  // Lowest set mask bit at or above 'from'; result is {found, index}.
  function automatic logic [2:0] first_from(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (int'(from) <= i)) begin
        res = {1'b1, 2'(i)};
      end
    end
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    mask_d  = mask_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    hit     = 3'b000;

    case (state_q)
      StIdle: begin
        if (in_valid && ready_q) begin
          word_d = in_data;
          mask_d = ch_en;
          hit    = first_from(ch_en, 3'd0);
          cnt_d  = 8'd0;
          if (hit[2]) begin
            state_d = StSlot;
            ch_d    = hit[1:0];
          end else begin
            state_d = StDone;
            ch_d    = 2'd0;
          end
        end
      end
      StSlot: begin
        if (cnt_q == HoldLast) begin
          hit   = first_from(mask_q, {1'b0, ch_q} + 3'd1);
          cnt_d = 8'd0;
          if (hit[2]) begin
            ch_d = hit[1:0];
          end else begin
            state_d = StDone;
            ch_d    = 2'd0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        word_d  = 4'd0;
        mask_d  = 4'd0;
        ch_d    = 2'd0;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state so din and {x,y} change on the same edge.
  always_comb begin
    din_d   = 1'b0;
    x_d     = 1'b0;
    y_d     = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ready_d = 1'b0;

    unique case (state_d)
      StIdle: begin
        ready_d = 1'b1;
      end
      StSlot: begin
        x_d    = ch_d[1];
        y_d    = ch_d[0];
        din_d  = word_d[ch_d];
        busy_d = 1'b1;
      end
      StDone: begin
        done_d = 1'b1;
      end
      default: begin
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      word_q  <= 4'd0;
      mask_q  <= 4'd0;
      ch_q    <= 2'd0;
      cnt_q   <= 8'd0;
      din_q   <= 1'b0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      x_q     <= x_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready = ready_q;
  assign din      = din_q;
  assign x        = x_q;
  assign y        = y_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
